// File: rtl/seg7_pkg.sv
// Package seg7_pkg: shared types, constants and the BCD-to-segment function
// for the calendar-clock 7-segment scan stage.
//   scan_state_t   two-phase scan FSM (blank interval / digit lit)
//   digit indices  SEC_U .. YEAR_TH, position of each field in the packed BCD bus
//   DP_MASK        digits whose decimal point is lit (hh.mm.ss and dd.mm.yyyy)
//   bcd_to_seg7    nibble -> {g,f,e,d,c,b,a}, active-high; nibbles >9 map to all-off
package seg7_pkg;

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } scan_state_t;

  localparam int unsigned SEC_U      = 0;
  localparam int unsigned SEC_T      = 1;
  localparam int unsigned MIN_U      = 2;
  localparam int unsigned MIN_T      = 3;
  localparam int unsigned HOUR_U     = 4;
  localparam int unsigned HOUR_T     = 5;
  localparam int unsigned DAY_U      = 6;
  localparam int unsigned DAY_T      = 7;
  localparam int unsigned MON_U      = 8;
  localparam int unsigned MON_T      = 9;
  localparam int unsigned YEAR_U     = 10;
  localparam int unsigned YEAR_T     = 11;
  localparam int unsigned YEAR_H     = 12;
  localparam int unsigned YEAR_TH    = 13;
  localparam int unsigned DIGITS_MAX = 14;

  // Bits 2,4 separate hh.mm.ss; bits 6,8 separate dd.mm.yyyy.
  localparam logic [DIGITS_MAX-1:0] DP_MASK = 14'h0154;

  function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD -> 7-segment decoder.
//   bcd  in  4  BCD nibble
//   seg  out 7  {g,f,e,d,c,b,a}, active-high, all-off for nibbles above 9
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = bcd_to_seg7(bcd);
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexes packed BCD time/date digits onto one shared
// 7-segment bus. New digits land in a shadow register and are copied to the
// display register only at frame start, so a frame never shows a torn update.
// Every digit is preceded by a blanking interval with all anodes off.
//   clk           in   1             system clock, posedge
//   rst           in   1             asynchronous reset, active-high
//   digits_bcd    in   4*NUM_DIGITS  packed BCD, digit 0 = seconds units
//   digits_valid  in   1             strobe: capture digits_bcd into shadow
//   seg           out  7             segments {g,f,e,d,c,b,a}, active-high
//   dp            out  1             decimal point, active-high
//   an            out  NUM_DIGITS    one-hot digit enable, zero while blanking
//   frame_start   out  1             pulse on the cycle the display register reloads
// Build option: define SEG7_SCAN_LZB_EN for leading-zero blanking of the
// year digits 13..11 (digit 10 always shown).
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 14,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic                    digits_valid,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0]   display_q, display_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      frame_start_q, frame_start_d;

  logic [3:0]                cur_bcd;
  logic [6:0]                dec_seg;
  logic                      dp_bit;
  logic                      lzb_blank;

  // Digit selected by the current index, taken from the display register.
  always_comb begin
    cur_bcd = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_bcd = display_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    dp_bit = 1'b0;
    for (int unsigned i = 0; i < DIGITS_MAX; i++) begin
      if (i < NUM_DIGITS && idx_q == IDX_W'(i)) begin
        dp_bit = DP_MASK[i];
      end
    end
  end

  seg7_decode u_decode (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

`ifdef SEG7_SCAN_LZB_EN
  generate
    if (NUM_DIGITS >= DIGITS_MAX) begin : g_lzb
      logic th_zero, h_zero, t_zero;
      // A year digit is blanked only when it and every more significant year
      // digit are zero, so zeros are suppressed from the top down.
      always_comb begin
        th_zero   = (display_q[4*YEAR_TH +: 4] == 4'd0);
        h_zero    = th_zero & (display_q[4*YEAR_H +: 4] == 4'd0);
        t_zero    = h_zero  & (display_q[4*YEAR_T +: 4] == 4'd0);
        lzb_blank = ((idx_q == IDX_W'(YEAR_TH)) & th_zero) |
                    ((idx_q == IDX_W'(YEAR_H))  & h_zero)  |
                    ((idx_q == IDX_W'(YEAR_T))  & t_zero);
      end
    end else begin : g_no_lzb
      always_comb begin
        lzb_blank = 1'b0;
      end
    end
  endgenerate
`else
  always_comb begin
    lzb_blank = 1'b0;
  end
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 1'b1;
    idx_d         = idx_q;
    display_d     = display_q;
    frame_start_d = 1'b0;
    shadow_d      = digits_valid ? digits_bcd : shadow_q;

    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end
      end
      S_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            // Frame start: reload from the pre-edge shadow, so a strobe on
            // this same edge is deferred to the following frame.
            idx_d         = '0;
            display_d     = shadow_q;
            frame_start_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state. The index only advances on
    // SHOW->BLANK, so on entry to S_SHOW idx_q already names the digit to light.
    an_d  = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (state_d == S_SHOW) begin
      an_d  = NUM_DIGITS'(1) << idx_q;
      seg_d = lzb_blank ? 7'b0000000 : dec_seg;
      dp_d  = dp_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      display_q     <= '0;
      seg_q         <= '0;
      dp_q          <= 1'b0;
      an_q          <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      display_q     <= display_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

  localparam int ND    = 14;
  localparam int RDIV  = 4;
  localparam int BLK   = 2;
  localparam int SLOT  = RDIV + BLK;
  localparam int FRAME = ND * SLOT;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [4*ND-1:0] digits_bcd = '0;
  logic            digits_valid = 1'b0;
  logic [6:0]      seg;
  logic            dp;
  logic [ND-1:0]   an;
  logic            frame_start;

  int tests = 0;
  int fails = 0;

  seg7_scan_mux #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RDIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digits_bcd   (digits_bcd),
    .digits_valid (digits_valid),
    .seg          (seg),
    .dp           (dp),
    .an           (an),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Position p = edges since reset release; frame = FRAME cycles of
  // ND slots, each BLK blank cycles followed by RDIV lit cycles.
  logic [6:0]      seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                     7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int              p = 0;
  logic [4*ND-1:0] m_shadow = '0;
  logic [4*ND-1:0] m_disp = '0;

  function automatic bit year_lead_zero(input logic [4*ND-1:0] d, input int dg);
    bit z = 1'b1;
    if (dg < 11) return 1'b0;
    for (int k = dg; k <= 13; k++) if (d[4*k +: 4] != 4'd0) z = 1'b0;
    return z;
  endfunction

  always @(posedge clk) begin
    int pos, dg, off;
    bit show;
    logic [3:0] nib;
    logic [ND-1:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fs;
    if (rst) begin
      p = 0;
      m_shadow = '0;
      m_disp = '0;
    end else begin
      p++;
      if (p % FRAME == 0) m_disp = m_shadow;
      if (digits_valid) m_shadow = digits_bcd;
    end
    #1;
    pos  = p % FRAME;
    dg   = pos / SLOT;
    off  = pos % SLOT;
    show = (off >= BLK);
    nib  = m_disp[4*dg +: 4];
    e_an  = show ? (ND'(1) << dg) : '0;
    e_seg = (show && nib <= 4'd9) ? seg_tbl[nib] : 7'h00;
`ifdef SEG7_SCAN_LZB_EN
    if (year_lead_zero(m_disp, dg)) e_seg = 7'h00;
`endif
    e_dp = show && (dg == 2 || dg == 4 || dg == 6 || dg == 8);
    e_fs = (p > 0) && (pos == 0);
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_seg", 32'(seg), 32'(e_seg));
    chk("model_dp", 32'(dp), 32'(e_dp));
    chk("model_fs", 32'(frame_start), 32'(e_fs));
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_an(input logic [ND-1:0] target, input string name);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (an !== target && n < 3 * FRAME);
    if (an !== target) chk({name, "_timeout"}, 32'(an), 32'(target));
  endtask

  task automatic wait_fs(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (frame_start !== 1'b1 && n < 2 * FRAME);
    if (frame_start !== 1'b1) chk({name, "_timeout"}, 32'(frame_start), 32'd1);
  endtask

  task automatic strobe(input logic [4*ND-1:0] v);
    @(negedge clk);
    digits_bcd   = v;
    digits_valid = 1'b1;
    @(negedge clk);
    digits_valid = 1'b0;
  endtask

  initial begin
    logic [4*ND-1:0] v;
    int n;
    v = '0;
    // 1: reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_blank_an", 32'(an), 32'h0);
    @(posedge clk); #1;
    chk("first_digit_an", 32'(an), 32'h0001);
    chk("first_digit_seg", 32'(seg), 32'h3F);
    @(posedge clk); #1;
    @(negedge clk) rst = 1'b1;
    #1;
    chk("async_rst_an", 32'(an), 32'h0);
    chk("async_rst_seg", 32'(seg), 32'h0);
    chk("async_rst_dp", 32'(dp), 32'h0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 2: scan sec=59 min=07
    v[3:0] = 4'd9; v[7:4] = 4'd5; v[11:8] = 4'd7; v[15:12] = 4'd0;
    strobe(v);
    wait_fs("scan_fs");
    wait_an(14'h0001, "scan_d0");
    chk("scan_d0_seg", 32'(seg), 32'h6F);
    wait_an(14'h0002, "scan_d1");
    chk("scan_d1_seg", 32'(seg), 32'h6D);
    wait_an(14'h0004, "scan_d2");
    chk("scan_d2_seg", 32'(seg), 32'h07);
    chk("scan_d2_dp", 32'(dp), 32'h1);
    wait_fs("period_fs0");
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (frame_start !== 1'b1 && n < 2 * FRAME);
    chk("frame_period", 32'(n), 32'(FRAME));

    // 3: tearing, strobe while digit 5 lit
    wait_an(14'h0020, "tear_d5");
    v[19:16] = 4'd2; v[23:20] = 4'd1;
    strobe(v);
    wait_fs("tear_fs");
    wait_an(14'h0010, "tear_next_d4");
    chk("tear_next_d4_seg", 32'(seg), 32'h5B);
    wait_an(14'h0020, "tear_next_d5");
    chk("tear_next_d5_seg", 32'(seg), 32'h06);

    // 3b/4: strobe coincident with frame_start, invalid nibble on digit 3
    wait_fs("coinc_fs0");
    repeat (FRAME - 1) @(posedge clk);
    @(negedge clk);
    v[15:12] = 4'hA;
    digits_bcd = v;
    digits_valid = 1'b1;
    @(posedge clk); #1;
    chk("coinc_fs", 32'(frame_start), 32'h1);
    @(negedge clk) digits_valid = 1'b0;
    wait_an(14'h0008, "coinc_old_d3");
    chk("coinc_old_d3_seg", 32'(seg), 32'h3F);
    wait_fs("inv_fs");
    wait_an(14'h0004, "inv_d2");
    chk("inv_d2_seg", 32'(seg), 32'h07);
    wait_an(14'h0008, "inv_d3");
    chk("inv_d3_seg", 32'(seg), 32'h00);
    chk("inv_d3_dp", 32'(dp), 32'h0);
    wait_an(14'h0010, "inv_d4");
    chk("inv_d4_seg", 32'(seg), 32'h5B);

    // 5: year 0024 then 0000
    v[43:40] = 4'd4; v[47:44] = 4'd2; v[51:48] = 4'd0; v[55:52] = 4'd0;
    strobe(v);
    wait_fs("y24_fs");
    wait_an(14'h0400, "y24_d10");
    chk("y24_d10_seg", 32'(seg), 32'h66);
    wait_an(14'h0800, "y24_d11");
    chk("y24_d11_seg", 32'(seg), 32'h5B);
    wait_an(14'h1000, "y24_d12");
`ifdef SEG7_SCAN_LZB_EN
    chk("y24_d12_seg", 32'(seg), 32'h00);
`else
    chk("y24_d12_seg", 32'(seg), 32'h3F);
`endif
    wait_an(14'h2000, "y24_d13");
`ifdef SEG7_SCAN_LZB_EN
    chk("y24_d13_seg", 32'(seg), 32'h00);
`else
    chk("y24_d13_seg", 32'(seg), 32'h3F);
`endif
    v[43:40] = 4'd0; v[47:44] = 4'd0;
    strobe(v);
    wait_fs("y00_fs");
    wait_an(14'h0400, "y00_d10");
    chk("y00_d10_seg", 32'(seg), 32'h3F);
    wait_an(14'h0800, "y00_d11");
`ifdef SEG7_SCAN_LZB_EN
    chk("y00_d11_seg", 32'(seg), 32'h00);
`else
    chk("y00_d11_seg", 32'(seg), 32'h3F);
`endif

    // 6: back-to-back strobes 30 then 31
    @(negedge clk);
    v[3:0] = 4'd0; v[7:4] = 4'd3;
    digits_bcd = v;
    digits_valid = 1'b1;
    @(negedge clk);
    v[3:0] = 4'd1;
    digits_bcd = v;
    @(negedge clk) digits_valid = 1'b0;
    wait_fs("b2b_fs");
    wait_an(14'h0001, "b2b_d0");
    chk("b2b_d0_seg", 32'(seg), 32'h06);
    wait_an(14'h0002, "b2b_d1");
    chk("b2b_d1_seg", 32'(seg), 32'h4F);

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
